// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM encoding and default sizing for seq_bubble_sort
package sort_pkg;

  localparam int DEF_N = 5;
  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - unsigned comparator returning the smaller and larger word
module sort_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic a_gt_b;

  assign a_gt_b = (a > b);
  assign lo     = a_gt_b ? b : a;
  assign hi     = a_gt_b ? a : b;

endmodule

// File: rtl/seq_bubble_sort.sv
// rtl/seq_bubble_sort.sv - frame bubble sorter, one compare-swap per cycle; SORT_DESCENDING_EN selects descending order
module seq_bubble_sort
  import sort_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_SLOT = IW'(N - 1);
  localparam logic [IW-1:0] LAST_CMP  = IW'(N - 2);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] count;
  logic [IW-1:0] idx;
  logic [IW-1:0] pass;
  logic          swapped;
  logic [W-1:0]  slot [N];

  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic [W-1:0]  cmp_lo;
  logic [W-1:0]  cmp_hi;
  logic [W-1:0]  wr_first;
  logic [W-1:0]  wr_second;
  logic          did_swap;
  logic          pass_done;
  logic          sort_done;

  assign cmp_a = slot[idx];
  assign cmp_b = slot[idx + 1'b1];

  sort_cmp_swap #(.W(W)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lo (cmp_lo),
    .hi (cmp_hi)
  );

`ifdef SORT_DESCENDING_EN
  assign wr_first  = cmp_hi;
  assign wr_second = cmp_lo;
`else
  assign wr_first  = cmp_lo;
  assign wr_second = cmp_hi;
`endif

  // A swap happened exactly when the word written back to slot j differs from what was there
  assign did_swap  = (wr_first != cmp_a);
  assign pass_done = (idx == LAST_CMP);
  assign sort_done = pass_done && (!(swapped || did_swap) || (pass == LAST_CMP));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_LOAD;
    else        state <= state_next;
  end

  // Next-state and handshake/output decode
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (count == LAST_SLOT)) state_next = ST_SORT;
      end
      ST_SORT: begin
        busy = 1'b1;
        if (sort_done) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = slot[count];
        out_last  = (count == LAST_SLOT);
        if (out_ready && (count == LAST_SLOT)) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // Slot storage, load/drain counter and pass/index bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count   <= '0;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            slot[count] <= in_data;
            count       <= (count == LAST_SLOT) ? '0 : count + 1'b1;
          end
        end
        ST_SORT: begin
          slot[idx]        <= wr_first;
          slot[idx + 1'b1] <= wr_second;
          if (pass_done) begin
            idx     <= '0;
            swapped <= 1'b0;
            pass    <= sort_done ? '0 : pass + 1'b1;
          end else begin
            idx     <= idx + 1'b1;
            swapped <= swapped | did_swap;
          end
        end
        ST_DRAIN: begin
          if (out_ready) count <= (count == LAST_SLOT) ? '0 : count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bubble_sort.sv
// tb/tb_seq_bubble_sort.sv - randomized self-checking bench for seq_bubble_sort against a sorted-queue model
module tb_seq_bubble_sort;

  localparam int N = 5;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int failures = 0;

  seq_bubble_sort #(.N(N), .W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bubble sort with early exit needs (max displacement + 1) passes, capped at N-1
  function automatic int exp_sort_cycles(input int v[N]);
    int d = 0;
    for (int i = 0; i < N; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) begin
`ifdef SORT_DESCENDING_EN
        if (v[j] < v[i]) c++;
`else
        if (v[j] > v[i]) c++;
`endif
      end
      if (c > d) d = c;
    end
    return ((d + 1) < (N - 1) ? (d + 1) : (N - 1)) * (N - 1);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input int v[N], input bit hold3);
    int q[$];
    int cyc;
    int k;
    int stall;
    foreach (v[i]) q.push_back(v[i]);
`ifdef SORT_DESCENDING_EN
    q.rsort();
`else
    q.sort();
`endif
    for (int b = 0; b < N; b++) begin
      @(negedge CLK);
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge CLK);
      end
      in_valid = 1'b1;
      in_data  = W'(v[b]);
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 0);
      @(posedge CLK);
    end
    @(negedge CLK);
    cyc = 0;
    while (busy && !out_valid && cyc < 100) begin
      if (cyc == 0) check("sort_in_ready", in_ready, 0);
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      out_ready = 1'($urandom);
      cyc++;
      @(negedge CLK);
    end
    check("sort_cycles", cyc, exp_sort_cycles(v));
    k = 0;
    stall = 0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      if (hold3 && k == 0 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      check("drain_valid", out_valid, 1);
      check("drain_in_ready", in_ready, 0);
      check("drain_data", out_data, q[k]);
      check("drain_last", out_last, (k == N - 1));
      @(posedge CLK);
      if (out_ready) k++;
      cyc++;
      @(negedge CLK);
    end
    check("drain_done", k, N);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("after_drain_out_valid", out_valid, 0);
    check("after_drain_busy", busy, 0);
    check("after_drain_in_ready", in_ready, 1);
  endtask

  initial begin
    int dir[5][N];
    int v[N];
    dir[0] = '{0, 5, 1, 3, 6};
    dir[1] = '{0, 1, 2, 3, 4};
    dir[2] = '{15, 9, 7, 3, 0};
    dir[3] = '{0, 0, 0, 0, 0};
    dir[4] = '{5, 5, 2, 2, 5};
    RST_N     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    RST_N = 1'b1;
    @(negedge CLK);
    check_idle("post_reset");

    for (int f = 0; f < 5; f++) begin
      v = dir[f];
      run_frame(v, (f == 4));
    end

    // Abort a partial frame with reset; the next frame must not see stale words
    for (int b = 0; b < 3; b++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = W'(9 + b);
      @(posedge CLK);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    RST_N    = 1'b0;
    @(negedge CLK);
    check_idle("mid_reset");
    RST_N = 1'b1;
    v = '{4, 3, 2, 1, 0};
    run_frame(v, 1'b0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, (1 << W) - 1));
      run_frame(v, (f % 4 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_bubble_sort.md
SEQ_BUBBLE_SORT -- requirements
Module: seq_bubble_sort

Interface
REQ-001 SHALL have parameter N, default 5, number of words per sort frame (N >= 2).
REQ-002 SHALL have parameter W, default 4, word width in bits.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input word present.
REQ-006 SHALL have port in_ready, output, 1, block accepts an input word.
REQ-007 SHALL have port in_data, input, W, unsigned input word.
REQ-008 SHALL have port out_valid, output, 1, output word present.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the output word.
REQ-010 SHALL have port out_data, output, W, sorted output word.
REQ-011 SHALL have port out_last, output, 1, marks the final word of a frame.
REQ-012 SHALL have port busy, output, 1, high in SORT and DRAIN.

Function
REQ-013 SHALL implement FSM states LOAD, SORT and DRAIN.
REQ-014 SHALL, in LOAD, drive in_ready=1 and store in_data into slot k on each in_valid&&in_ready beat (k = 0..N-1, in arrival order).
REQ-015 SHALL go LOAD->SORT on the cycle after the Nth accepted beat; in_ready SHALL be 0 outside LOAD.
REQ-016 SHALL, in SORT, perform exactly one adjacent compare-swap per cycle, with index j running 0..N-2 per pass; swap when slot[j] > slot[j+1] (unsigned).
REQ-017 SHALL track a per-pass swap flag and go SORT->DRAIN after the first pass with zero swaps or after N-1 passes, whichever comes first.
REQ-018 SHALL therefore spend N-1 cycles in SORT for an already-sorted frame and at most (N-1)^2 cycles for a reverse-sorted frame.
REQ-019 SHALL, in DRAIN, present slot 0..N-1 in order with out_valid=1, advancing only on out_valid&&out_ready; out_last=1 only with slot N-1.
REQ-020 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL go DRAIN->LOAD on the cycle after the last word is accepted; out_valid SHALL be 0 outside DRAIN.
REQ-022 SHALL sort equal words without error; relative order of duplicates is irrelevant because words carry no payload.
REQ-023 SHALL ignore in_valid outside LOAD and out_ready outside DRAIN.

Reset
REQ-024 SHALL, while RST_N=0, force state LOAD, load count 0, pass/index counters 0, all slots 0, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-025 SHALL, on reset assertion in any state, discard the partial frame; the first accepted beat after release is slot 0 of a new frame.

Configuration
REQ-026 SHALL use macro SORT_DESCENDING_EN: when defined, the swap condition is slot[j] < slot[j+1] and the output order is descending. When not defined, the output order is ascending per REQ-016.

Structure
REQ-027 SHALL place the FSM state encoding and the default N and W constants in shared package sort_pkg.
REQ-028 SHALL implement the comparator and conditional swap as sub-module sort_cmp_swap (inputs a, b; outputs lo, hi). The macro from REQ-026 SHALL only swap which of lo/hi is written back.

Verification
REQ-029 SHALL cover this case: input frame 0,5,1,3,6 with out_ready=1 -> 2 passes (8 SORT cycles); output 0,1,3,5,6 with out_last on 6.
REQ-030 SHALL cover this case: input 0,1,2,3,4 (already sorted) -> SORT lasts exactly 4 cycles; output 0,1,2,3,4.
REQ-031 SHALL cover this case: input 15,9,7,3,0 (reversed) -> SORT lasts 16 cycles; output 0,3,7,9,15.
REQ-032 SHALL cover this case: input 0,0,0,0,0, then input 5,5,2,2,5 -> outputs 0,0,0,0,0 then 2,2,5,5,5. During DRAIN, hold out_ready=0 for 3 cycles -> out_data remains stable.
REQ-033 SHALL cover this case: pulse RST_N low after 3 of 5 beats, then send 4,3,2,1,0 -> output 0,1,2,3,4 with no stale words.
REQ-034 SHALL cover this case: with SORT_DESCENDING_EN defined, input 0,5,1,3,6 -> output 6,5,3,1,0.
